// File: rtl/data_mem_lsu.sv
// Load/store responder: word/half/byte accesses on a word-wide synchronous RAM,
// with read-modify-write for sub-word stores and sign/zero-extended loads.
`timescale 1ns/1ps
module data_mem_lsu #(
    parameter int DEPTH_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        rw,
    input  logic [1:0]  whb,
    input  logic        ld_unsigned,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        rsp_valid,
    output logic [31:0] rdata,
    output logic        misalign
);

    localparam int AW = $clog2(DEPTH_WORDS);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [2:0] {IDLE, READ, WRITE, MERGE, RESP} state_t;

    state_t state_reg, state_next;

    logic          rw_reg;
    logic [1:0]    whb_reg;
    logic          uns_reg;
    logic [AW+1:0] addr_reg;
    logic [31:0]   wdata_reg;

    // Response formatting fields, updated only when entering RESP so that
    // rdata/misalign stay stable until the next response.
    logic          resp_load_reg;
    logic [1:0]    resp_whb_reg;
    logic          resp_uns_reg;
    logic [1:0]    resp_lane_reg;
    logic          misalign_reg;

    logic [31:0]   mem [DEPTH_WORDS];
    logic [31:0]   ld_word_reg;
    logic [31:0]   mg_word_reg;
    logic [31:0]   merged_word;
    logic [31:0]   ram_wdata;
    logic [AW-1:0] word_idx;
    logic          ram_we;
    logic          accept;
    logic          req_err;

    logic addr_hi_unused;
    assign addr_hi_unused = ^addr[31:AW+2];

    assign word_idx = addr_reg[AW+1:2];

    assign req_err = (whb == 2'b11)
                  || (whb == SZ_HALF && addr[0])
                  || (whb == SZ_WORD && addr[1:0] != 2'b00);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    if (req_err)
                        state_next = RESP;
                    else if (!rw && whb == SZ_WORD)
                        state_next = WRITE;
                    else
                        state_next = READ;
                end
            end
            READ:    state_next = rw_reg ? RESP : MERGE;
            WRITE:   state_next = RESP;
            MERGE:   state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        ram_we    = 1'b0;
        ram_wdata = merged_word;
        unique case (state_reg)
            IDLE:  req_ready = 1'b1;
            WRITE: begin
                ram_we    = 1'b1;
                ram_wdata = wdata_reg;
            end
            MERGE: ram_we = 1'b1;
            RESP:  rsp_valid = 1'b1;
            default: ;
        endcase
    end

    assign accept = req_valid && req_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rw_reg        <= 1'b0;
            whb_reg       <= 2'b00;
            uns_reg       <= 1'b0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            resp_load_reg <= 1'b0;
            resp_whb_reg  <= 2'b00;
            resp_uns_reg  <= 1'b0;
            resp_lane_reg <= 2'b00;
            misalign_reg  <= 1'b0;
        end else begin
            if (accept) begin
                rw_reg    <= rw;
                whb_reg   <= whb;
                uns_reg   <= ld_unsigned;
                addr_reg  <= addr[AW+1:0];
                wdata_reg <= wdata;
            end
            if (state_next == RESP) begin
                // Entering RESP straight from IDLE only happens for rejected requests.
                if (state_reg == IDLE) begin
                    resp_load_reg <= 1'b0;
                    misalign_reg  <= 1'b1;
                end else begin
                    resp_load_reg <= rw_reg;
                    misalign_reg  <= 1'b0;
                end
                resp_whb_reg  <= whb_reg;
                resp_uns_reg  <= uns_reg;
                resp_lane_reg <= addr_reg[1:0];
            end
        end
    end

    // RAM with registered read; loads and merges keep separate read registers
    // so a sub-word store never disturbs the held load result.
    always_ff @(posedge clk) begin
        if (ram_we)
            mem[word_idx] <= ram_wdata;
        if (state_reg == READ) begin
            if (rw_reg)
                ld_word_reg <= mem[word_idx];
            else
                mg_word_reg <= mem[word_idx];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic       hit;
            logic [7:0] src;
            assign hit = (whb_reg == SZ_BYTE) ? (addr_reg[1:0] == 2'(gi))
                                              : (addr_reg[1] == 1'(gi / 2));
            assign src = (whb_reg == SZ_BYTE) ? wdata_reg[7:0]
                                              : wdata_reg[8*(gi%2) +: 8];
            assign merged_word[8*gi +: 8] = hit ? src : mg_word_reg[8*gi +: 8];
        end
    endgenerate

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign ld_byte = ld_word_reg[{resp_lane_reg, 3'b000} +: 8];
    assign ld_half = ld_word_reg[{resp_lane_reg[1], 4'b0000} +: 16];

    always_comb begin
        rdata = 32'h0;
        if (resp_load_reg) begin
            unique case (resp_whb_reg)
                SZ_BYTE: rdata = {{24{~resp_uns_reg & ld_byte[7]}}, ld_byte};
                SZ_HALF: rdata = {{16{~resp_uns_reg & ld_half[15]}}, ld_half};
                default: rdata = ld_word_reg;
            endcase
        end
    end

    assign misalign = misalign_reg;

endmodule

// File: tb/tb_data_mem_lsu.sv
// Self-checking bench for data_mem_lsu: directed vector table, reset-abort
// sequence and randomized traffic against a byte-array reference model.
`timescale 1ns/1ps
module tb_data_mem_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        rw;
    logic [1:0]  whb;
    logic        ld_unsigned;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rsp_valid;
    logic [31:0] rdata;
    logic        misalign;

    always #5 clk = ~clk;

    data_mem_lsu #(.DEPTH_WORDS(256)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .rw(rw), .whb(whb), .ld_unsigned(ld_unsigned), .addr(addr), .wdata(wdata),
        .rsp_valid(rsp_valid), .rdata(rdata), .misalign(misalign)
    );

    int errors = 0;
    int checks = 0;

    bit [7:0] model_mem [1024];

    typedef struct {
        bit        rw;
        bit [1:0]  whb;
        bit        uns;
        bit [31:0] addr;
        bit [31:0] wdata;
        bit [31:0] exp_rdata;
        bit        exp_mis;
        int        exp_lat;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit r, input bit [1:0] w, input bit u, input bit [31:0] a,
                       input bit [31:0] d, input bit [31:0] er, input bit em, input int el);
        vec_t v;
        v.rw = r; v.whb = w; v.uns = u; v.addr = a; v.wdata = d;
        v.exp_rdata = er; v.exp_mis = em; v.exp_lat = el;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%08h expected=%08h", name, got, exp);
        end
    endtask

    // Reference model: memory as a flat byte array, addresses wrap at 1 KiB.
    task automatic model_op(input bit r, input bit [1:0] w, input bit u, input bit [31:0] a,
                            input bit [31:0] d, output bit [31:0] er, output bit em,
                            output int el);
        int n;
        int base;
        bit [31:0] v;
        base = int'(a[9:0]);
        n = (w == 2'd0) ? 1 : (w == 2'd1) ? 2 : 4;
        em = (w == 2'd3) || (w == 2'd1 && a[0]) || (w == 2'd2 && a[1:0] != 2'd0);
        er = 32'h0;
        if (em) begin
            el = 1;
        end else if (r) begin
            el = 2;
            v = 32'h0;
            for (int i = 0; i < n; i++)
                v |= 32'(model_mem[base + i]) << (8 * i);
            if (n < 4 && !u && v[8*n-1])
                v |= 32'hFFFF_FFFF << (8 * n);
            er = v;
        end else begin
            el = (n == 4) ? 2 : 3;
            for (int i = 0; i < n; i++)
                model_mem[base + i] = d[8*i +: 8];
        end
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    task automatic do_req(input string name, input bit r, input bit [1:0] w, input bit u,
                          input bit [31:0] a, input bit [31:0] d,
                          input bit [31:0] er, input bit em, input int el);
        int lat;
        logic [31:0] got_rdata;
        logic        got_mis;
        chk({name, "_ready"}, 32'(req_ready), 32'd1);
        rw = r; whb = w; ld_unsigned = u; addr = a; wdata = d; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rw = 1'($urandom); whb = 2'($urandom); ld_unsigned = 1'($urandom);
        addr = $urandom; wdata = $urandom;
        lat = 0;
        got_rdata = 32'h0;
        got_mis = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (rsp_valid) begin
                lat = c;
                got_rdata = rdata;
                got_mis = misalign;
                break;
            end
        end
        chk({name, "_latency"}, 32'(lat), 32'(el));
        chk({name, "_rdata"}, got_rdata, er);
        chk({name, "_misalign"}, 32'(got_mis), 32'(em));
        @(negedge clk);
        chk({name, "_pulse"}, 32'(rsp_valid), 32'd0);
        chk({name, "_idle_ready"}, 32'(req_ready), 32'd1);
        chk({name, "_rdata_hold"}, rdata, er);
        $display("%s rw=%0d whb=%0d uns=%0d addr=%08h wdata=%08h -> rdata=%08h mis=%0d lat=%0d",
                 name, r, w, u, a, d, got_rdata, got_mis, lat);
    endtask

    initial begin
        bit [31:0] er;
        bit        em;
        int        el;
        bit        r;
        bit [1:0]  w;
        bit        u;
        bit [31:0] a;
        bit [31:0] d;
        int        sel;

        rst_n = 1'b0; req_valid = 1'b0; rw = 1'b0; whb = 2'b00;
        ld_unsigned = 1'b0; addr = 32'h0; wdata = 32'h0;
        #1;
        chk("reset_ready", 32'(req_ready), 32'd1);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rdata", rdata, 32'h0);
        chk("reset_misalign", 32'(misalign), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        add(0, 2, 0, 32'h10,  32'hDEADBEEF, 32'h0,        0, 2);
        add(1, 2, 0, 32'h10,  32'h0,        32'hDEADBEEF, 0, 2);
        add(0, 2, 0, 32'h20,  32'h11223344, 32'h0,        0, 2);
        add(0, 0, 0, 32'h22,  32'h000000AA, 32'h0,        0, 3);
        add(1, 2, 0, 32'h20,  32'h0,        32'h11AA3344, 0, 2);
        add(0, 1, 0, 32'h22,  32'h1234BEEF, 32'h0,        0, 3);
        add(1, 2, 0, 32'h20,  32'h0,        32'hBEEF3344, 0, 2);
        add(0, 2, 0, 32'h30,  32'h8001F0FF, 32'h0,        0, 2);
        add(1, 1, 0, 32'h32,  32'h0,        32'hFFFF8001, 0, 2);
        add(1, 1, 1, 32'h32,  32'h0,        32'h00008001, 0, 2);
        add(1, 0, 0, 32'h30,  32'h0,        32'hFFFFFFFF, 0, 2);
        add(1, 0, 1, 32'h31,  32'h0,        32'h000000F0, 0, 2);
        add(1, 0, 0, 32'h31,  32'h0,        32'hFFFFFFF0, 0, 2);
        add(1, 2, 0, 32'h31,  32'h0,        32'h0,        1, 1);
        add(0, 1, 0, 32'h33,  32'h00001234, 32'h0,        1, 1);
        add(1, 2, 0, 32'h30,  32'h0,        32'h8001F0FF, 0, 2);
        add(0, 2, 0, 32'h40,  32'h0BADF00D, 32'h0,        0, 2);
        add(0, 3, 0, 32'h40,  32'hFFFFFFFF, 32'h0,        1, 1);
        add(1, 2, 0, 32'h40,  32'h0,        32'h0BADF00D, 0, 2);
        add(0, 2, 0, 32'h400, 32'h00000005, 32'h0,        0, 2);
        add(1, 2, 0, 32'h0,   32'h0,        32'h00000005, 0, 2);
        add(0, 2, 0, 32'h50,  32'h0,        32'h0,        0, 2);
        add(1, 2, 0, 32'h10,  32'h0,        32'hDEADBEEF, 0, 2);

        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            model_op(vecs[i].rw, vecs[i].whb, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
                     er, em, el);
            do_req($sformatf("vec%0d", i), vecs[i].rw, vecs[i].whb, vecs[i].uns,
                   vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_mis,
                   vecs[i].exp_lat);
        end

        // SB 0xFF @0x50 aborted by reset while in MERGE.
        rw = 1'b0; whb = 2'b00; ld_unsigned = 1'b0; addr = 32'h50; wdata = 32'hFF;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("rmw_read_no_rsp", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk("rmw_merge_no_rsp", 32'(rsp_valid), 32'd0);
        rst_n = 1'b0;
        // A request presented during reset must not be accepted.
        rw = 1'b0; whb = 2'b10; addr = 32'h50; wdata = 32'hBAD0BAD0; req_valid = 1'b1;
        #1;
        chk("abort_ready", 32'(req_ready), 32'd1);
        chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("abort_rdata", rdata, 32'h0);
        chk("abort_misalign", 32'(misalign), 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("abort_hold_rsp", 32'(rsp_valid), 32'd0);
            chk("abort_hold_rdata", rdata, 32'h0);
        end
        req_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_abort_no_rsp", 32'(rsp_valid), 32'd0);
        model_op(1, 2, 0, 32'h50, 32'h0, er, em, el);
        do_req("post_abort_lw", 1, 2, 0, 32'h50, 32'h0, er, em, el);

        // Fill every word so all later loads compare against known contents.
        for (int i = 0; i < 256; i++) begin
            d = $urandom;
            model_op(0, 2, 0, 32'(i * 4), d, er, em, el);
            do_req($sformatf("init%0d", i), 0, 2, 0, 32'(i * 4), d, er, em, el);
        end

        for (int i = 0; i < 300; i++) begin
            r = 1'($urandom);
            sel = $urandom_range(0, 9);
            w = (sel == 0) ? 2'd3 : (sel < 4) ? 2'd0 : (sel < 7) ? 2'd1 : 2'd2;
            u = 1'($urandom);
            a = $urandom;
            d = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (w == 2'd1) a[0] = 1'b0;
                if (w == 2'd2) a[1:0] = 2'b00;
            end
            model_op(r, w, u, a, d, er, em, el);
            do_req($sformatf("rnd%0d", i), r, w, u, a, d, er, em, el);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/data_mem_lsu.md
# data_mem_lsu

Load/store responder for the single-cycle RISC-V datapath: consumes the memory-side control produced by instruction decode (`rw`, `whb`) plus the ALU-computed address and the rs2 store data, and performs word/halfword/byte accesses on an internal word-wide synchronous RAM. Sub-word stores are done as read-modify-write. Loads return sign- or zero-extended data. Misaligned or reserved-size requests are rejected with an error flag and never touch memory. It sits between the ALU result and the writeback mux (MemtoReg path).

## Interface
- `DEPTH_WORDS`, 256, number of 32-bit words in the RAM; power of two.
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  asynchronous, active-low reset.
- `req_valid`  input  1  request present.
- `req_ready`  output  1  block can accept; high only in IDLE.
- `rw`  input  1  1 = load, 0 = store (decode encoding).
- `whb`  input  2  size: 2'b10 word, 2'b01 half, 2'b00 byte, 2'b11 reserved.
- `ld_unsigned`  input  1  zero-extend sub-word loads (funct3[2]); ignored for word loads and stores.
- `addr`  input  32  byte address.
- `wdata`  input  32  store data; the byte/half is taken from the low bits.
- `rsp_valid`  output  1  one-cycle completion pulse.
- `rdata`  output  32  load result; valid with `rsp_valid`.
- `misalign`  output  1  request rejected; valid with `rsp_valid`.

## Operation
- Word index is `addr[log2(DEPTH_WORDS)+1:2]`. Upper address bits are ignored, so addresses wrap modulo 4*DEPTH_WORDS bytes.
- Request capture: the accept is `req_valid && req_ready` at a rising edge. `rw`, `whb`, `ld_unsigned`, `addr` and `wdata` are registered at that edge. Inputs need not be held afterwards.
- A request is an error when any of these hold: `whb`=11; half with `addr[0]`=1; word with `addr[1:0]`≠0.
- Lane selection:
  - Byte lane n = `addr[1:0]`, occupying bits [8n+7:8n].
  - Half lane h = `addr[1]`, occupying bits [16h+15:16h].
- FSM states: IDLE, READ, WRITE, MERGE, RESP.
  - IDLE: `req_ready`=1. On accept:
    - error request -> RESP;
    - word store -> WRITE;
    - load or sub-word store -> READ.
  - READ: issue a synchronous read of the captured word index. Next state is RESP for a load, MERGE for a sub-word store.
  - WRITE: write `wdata` to the full word -> RESP.
  - MERGE: replace only the addressed lane of the read word with `wdata[7:0]` or `wdata[15:0]`, write the merged word back -> RESP.
  - RESP: `rsp_valid`=1 for exactly this cycle -> IDLE.
- Response contents:
  - Load: `rdata` = selected lane, sign-extended from the lane MSB, or zero-extended when `ld_unsigned`=1. A word load returns the raw word.
  - Store or error: `rdata`=0.
  - `misalign`=1 only for error requests. The RAM is unchanged for error requests.
- There is no response backpressure. `rdata` and `misalign` hold their values until the next RESP.
- RAM contents are not reset.

## Timing
- Reset values while `rst_n`=0: state IDLE, `req_ready`=1, `rsp_valid`=0, `rdata`=0, `misalign`=0. No request is accepted while `rst_n` is low.
- Latency, counted from the accept edge to the cycle in which `rsp_valid` is high:
  - error: 1 cycle;
  - word store: 2 cycles;
  - load: 2 cycles;
  - sub-word store: 3 cycles.
- The RAM write happens at the rising edge that leaves WRITE or MERGE.
- The RAM read is registered: data is captured at the edge that leaves READ.
- Back-to-back: `req_ready` rises in the cycle after RESP. Minimum request spacing is therefore latency + 1 cycles.
- A store followed by a load to the same word returns the new data, because the write is committed before IDLE.
- Reset asserted mid-operation: the operation is abandoned and no `rsp_valid` is issued.
  - If reset hits in READ or MERGE before the write edge, the RAM is unchanged.
  - A write already committed at an earlier edge persists.
- `req_valid` held high through a transaction is not re-accepted until IDLE.

## Test plan
- Word store then word load: SW 0xDEADBEEF @0x10, then LW @0x10 -> `rsp_valid` 2 cycles after each accept; `rdata`=0xDEADBEEF; `misalign`=0.
- Byte merge: SW 0x11223344 @0x20, then SB `wdata`=0xAA @0x22, then LW @0x20 -> SB responds after 3 cycles; `rdata`=0x11AA3344.
- Sign/zero extension: word 0x8001F0FF at @0x30.
  - LH @0x32 -> 0xFFFF8001; LHU @0x32 -> 0x00008001.
  - LB @0x30 -> 0xFFFFFFFF; LBU @0x31 -> 0x000000F0.
- Misaligned requests: LW @0x31, SH @0x33, and `whb`=11 @0x40 -> each gives `rsp_valid` 1 cycle after accept, `misalign`=1, `rdata`=0. A following LW of the affected word shows it unchanged.
- Wrap-around: with DEPTH_WORDS=256, SW 0x5 @0x400 then LW @0x0 -> `rdata`=0x5.
- Reset mid-RMW: SW 0x0 @0x50; SB 0xFF @0x50; assert `rst_n`=0 while in MERGE. Release, then LW @0x50 -> `rdata`=0x0. No `rsp_valid` for the aborted SB. All outputs at reset values during reset.
